// File: rtl/data_sram_resp.sv
// Data-SRAM port responder: word RAM with byte-lane writes plus a small peripheral
// window (timer, LED, switches, scratch). Every read returns data exactly one cycle later.
module data_sram_resp #(
  parameter int          ADDR_W      = 12,
  parameter logic [15:0] PERIPH_BASE = 16'hBFAF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  input  logic [7:0]  sw
);

  localparam logic [15:0] OFF_TIMER   = 16'hE000;
  localparam logic [15:0] OFF_LED     = 16'hF000;
  localparam logic [15:0] OFF_SW      = 16'hF010;
  localparam logic [15:0] OFF_SCRATCH = 16'hF100;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  logic [31:0] rdata_q, rdata_d;
  logic [31:0] timer_q, timer_d;
  logic [15:0] led_q, led_d;
  logic [31:0] scratch_q, scratch_d;
  logic [7:0]  sw_meta_q, sw_sync_q;

  logic              is_periph;
  logic [15:0]       offset;
  logic [ADDR_W-1:0] ram_idx;
  logic              req_rd, req_wr;
  logic [31:0]       periph_rdata;
  logic              unused_addr;

  assign is_periph   = (data_sram_addr[31:16] == PERIPH_BASE);
  assign offset      = data_sram_addr[15:0];
  assign ram_idx     = data_sram_addr[ADDR_W+1:2];
  assign unused_addr = ^data_sram_addr[1:0];

  // Requests arriving while rst is asserted are dropped entirely.
  assign req_rd = rst & data_sram_en & (data_sram_wen == 4'h0);
  assign req_wr = rst & data_sram_en & (data_sram_wen != 4'h0);

  always_comb begin
    periph_rdata = 32'h0;
    case (offset)
      OFF_TIMER:   periph_rdata = timer_q;
      OFF_LED:     periph_rdata = {16'h0, led_q};
      OFF_SW:      periph_rdata = {24'h0, sw_sync_q};
      OFF_SCRATCH: periph_rdata = scratch_q;
      default:     periph_rdata = 32'h0;
    endcase
  end

  always_comb begin
    rdata_d   = rdata_q;
    timer_d   = timer_q + 32'd1;
    led_d     = led_q;
    scratch_d = scratch_q;
    if (req_rd)
      rdata_d = is_periph ? periph_rdata : mem[ram_idx];
    if (req_wr && is_periph) begin
      case (offset)
        OFF_TIMER:
          if (data_sram_wen == 4'hF) timer_d = data_sram_wdata;
        OFF_LED: begin
          if (data_sram_wen[0]) led_d[7:0]  = data_sram_wdata[7:0];
          if (data_sram_wen[1]) led_d[15:8] = data_sram_wdata[15:8];
        end
        OFF_SCRATCH:
          for (int i = 0; i < 4; i++)
            if (data_sram_wen[i]) scratch_d[8*i +: 8] = data_sram_wdata[8*i +: 8];
        default: ;
      endcase
    end
  end

  // RAM is not reset; writes commit at the edge so a following read sees them.
  always_ff @(posedge clk) begin
    if (req_wr && !is_periph)
      for (int i = 0; i < 4; i++)
        if (data_sram_wen[i]) mem[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q   <= 32'h0;
      timer_q   <= 32'h0;
      led_q     <= 16'h0;
      scratch_q <= 32'h0;
      sw_meta_q <= 8'h0;
      sw_sync_q <= 8'h0;
    end else begin
      rdata_q   <= rdata_d;
      timer_q   <= timer_d;
      led_q     <= led_d;
      scratch_q <= scratch_d;
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign data_sram_rdata = rdata_q;
  assign led             = led_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Scenario bench for data_sram_resp: expected read data is queued when a request is
// driven and compared one edge later when rdata updates.
module tb_data_sram_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [15:0] led;
  logic [7:0]  sw;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    string       name;
  } exp_t;
  exp_t sb[$];

  data_sram_resp #(.ADDR_W(12), .PERIPH_BASE(16'hBFAF)) dut (
    .clk(clk), .rst(rst), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata),
    .led(led), .sw(sw)
  );

  always #5 clk = ~clk;

  // One clock cycle: drive request on negedge, queue expectation, compare after the edge.
  task automatic do_cycle(input logic r, input logic e, input logic [3:0] w,
                          input logic [31:0] a, input logic [31:0] d,
                          input bit chk, input logic [31:0] exp, input string name);
    exp_t item;
    @(negedge clk);
    rst = r; en = e; wen = w; addr = a; wdata = d;
    item.chk = chk; item.exp = exp; item.name = name;
    sb.push_back(item);
    @(posedge clk);
    #1;
    item = sb.pop_front();
    if (item.chk) begin
      checks++;
      if (rdata !== item.exp) begin
        errors++;
        $display("FAIL %s: rdata=%h expected=%h", item.name, rdata, item.exp);
      end
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    do_cycle(1'b1, 1'b1, 4'h0, a, 32'h0, 1'b1, exp, name);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    do_cycle(1'b1, 1'b1, w, a, d, 1'b0, 32'h0, "");
  endtask

  task automatic idle();
    do_cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, "");
  endtask

  task automatic check_led(input logic [15:0] exp, input string name);
    checks++;
    if (led !== exp) begin
      errors++;
      $display("FAIL %s: led=%h expected=%h", name, led, exp);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++)
      do_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, "");
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: rdata=%h expected=%h", rdata, 32'h0);
    end
    check_led(16'h0, "reset_led");
    rd(32'hBFAFE000, 32'h0, "timer_after_reset_0");
    rd(32'hBFAFE000, 32'h1, "timer_after_reset_1");
  endtask

  task automatic test_ram();
    wr(32'h00000100, 4'hF, 32'hDEADBEEF);
    rd(32'h00000100, 32'hDEADBEEF, "ram_read");
    rd(32'h00004100, 32'hDEADBEEF, "ram_alias");
  endtask

  task automatic test_byte_lanes();
    wr(32'h00000104, 4'hF, 32'h11223344);
    wr(32'h00000104, 4'b0101, 32'hAABBCCDD);
    rd(32'h00000104, 32'h11BB33DD, "byte_lanes");
  endtask

  task automatic test_led_scratch();
    wr(32'hBFAFF000, 4'hF, 32'hFFFF1234);
    check_led(16'h1234, "led_write");
    rd(32'hBFAFF000, 32'h00001234, "led_read");
    wr(32'hBFAFF000, 4'hC, 32'h00000000);
    check_led(16'h1234, "led_upper_lanes_ignored");
    wr(32'hBFAFF100, 4'b1000, 32'h7F000000);
    rd(32'hBFAFF100, 32'h7F000000, "scratch_byte3");
  endtask

  task automatic test_timer();
    wr(32'hBFAFE000, 4'hF, 32'hFFFFFFFE);
    rd(32'hBFAFE000, 32'hFFFFFFFE, "timer_loaded");
    rd(32'hBFAFE000, 32'hFFFFFFFF, "timer_pre_wrap");
    rd(32'hBFAFE000, 32'h00000000, "timer_wrap");
    wr(32'hBFAFE000, 4'hF, 32'd100);
    wr(32'hBFAFE000, 4'h1, 32'h0);
    rd(32'hBFAFE000, 32'd101, "timer_partial_ignored");
  endtask

  task automatic test_sw_unmapped();
    @(negedge clk);
    sw = 8'hA5;
    @(posedge clk);
    #1;
    rd(32'hBFAFF010, 32'h00000000, "sw_old");
    rd(32'hBFAFF010, 32'h000000A5, "sw_new");
    // rdata must hold across a write
    do_cycle(1'b1, 1'b1, 4'hF, 32'hBFAFF010, 32'h0, 1'b1, 32'h000000A5, "rdata_hold_on_write");
    rd(32'hBFAFF010, 32'h000000A5, "sw_write_ignored");
    rd(32'hBFAF0040, 32'h0, "unmapped");
  endtask

  task automatic test_back_to_back();
    wr(32'h00000300, 4'hF, 32'h01010101);
    wr(32'h00000304, 4'hF, 32'h02020202);
    rd(32'h00000300, 32'h01010101, "b2b_0");
    rd(32'h00000304, 32'h02020202, "b2b_1");
    rd(32'h00000300, 32'h01010101, "b2b_2");
  endtask

  task automatic test_reset_mid();
    wr(32'h00000200, 4'hF, 32'h12345678);
    rd(32'h00000200, 32'h12345678, "pre_reset_ram");
    do_cycle(1'b0, 1'b1, 4'hF, 32'h00000200, 32'hCAFEF00D, 1'b1, 32'h0, "mid_reset_rdata");
    check_led(16'h0, "mid_reset_led");
    rd(32'hBFAFE000, 32'h0, "timer_restart");
    rd(32'h00000200, 32'h12345678, "write_dropped_in_reset");
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0; sw = 8'h00;
    test_reset();
    test_ram();
    test_byte_lanes();
    test_led_scratch();
    test_timer();
    test_sw_unmapped();
    test_back_to_back();
    test_reset_mid();
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
